// File: rtl/seq_pkg.sv
// seq_pkg: opcodes, func one-hot codes, ALU codes and states for mc_sequencer.
package seq_pkg;
   localparam logic [3:0] OP_ALU   = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_JMP   = 4'h4;
   localparam logic [3:0] OP_BZ    = 4'h8;
   localparam logic [3:0] OP_HALT  = 4'hF;
   localparam logic [7:0] F_MOVE = 8'h01;
   localparam logic [7:0] F_ADD  = 8'h02;
   localparam logic [7:0] F_SUB  = 8'h04;
   localparam logic [7:0] F_AND  = 8'h08;
   localparam logic [7:0] F_OR   = 8'h10;
   localparam logic [7:0] F_NOT  = 8'h20;
   localparam logic [7:0] F_NOP  = 8'h40;
   localparam logic [7:0] F_WND  = 8'h80;
   localparam logic [3:0] A_MOVE = 4'd0;
   localparam logic [3:0] A_ADD  = 4'd1;
   localparam logic [3:0] A_SUB  = 4'd2;
   localparam logic [3:0] A_AND  = 4'd3;
   localparam logic [3:0] A_OR   = 4'd4;
   localparam logic [3:0] A_NOT  = 4'd5;
   localparam logic [3:0] A_NOP  = 4'd6;
   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WR, S_HALT, S_FAULT
   } state_t;
endpackage

// File: rtl/seq_func_dec.sv
// seq_func_dec: combinational decoder of the one-hot ALU func field.
module seq_func_dec
   import seq_pkg::*;
(
   input  logic [7:0] func,
   output logic [3:0] alu_func,
   output logic       reg_we,
   output logic       wnd_ld,
   output logic       illegal
);
   always_comb begin
      alu_func = A_NOP;
      reg_we   = 1'b1;
      wnd_ld   = 1'b0;
      illegal  = 1'b0;
      case (func)
         F_MOVE: alu_func = A_MOVE;
         F_ADD:  alu_func = A_ADD;
         F_SUB:  alu_func = A_SUB;
         F_AND:  alu_func = A_AND;
         F_OR:   alu_func = A_OR;
         F_NOT:  alu_func = A_NOT;
         F_NOP:  reg_we = 1'b0;
         default: begin
            reg_we  = 1'b0;
            wnd_ld  = func[7:2] == F_WND[7:2];
            illegal = func[7:2] != F_WND[7:2];
         end
      endcase
   end
endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle fetch/decode/execute control sequencer.
// SEQ_TIMEOUT_EN builds the memory-timeout counter and the FAULT state.
module mc_sequencer
   import seq_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instr,
   input  logic        zero,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic        addr_sel,
   output logic        ir_ld,
   output logic        pc_ld,
   output logic        pc_src,
   output logic [3:0]  alu_func,
   output logic        reg_we,
   output logic        reg_src,
   output logic        wnd_ld,
   output logic [1:0]  window,
   output logic        illegal,
   output logic        halted,
   output logic        fault
);
   state_t r_state, w_next;
   logic [3:0] w_op;
   logic [7:0] w_func;
   logic [3:0] w_dec_alu;
   logic w_dec_we, w_dec_wnd, w_dec_ill, w_mem_st, w_tmo;
   assign w_op     = instr[15:12];
   assign w_func   = instr[7:0];
   assign w_mem_st = r_state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
   seq_func_dec u_dec (
      .func     (w_func),
      .alu_func (w_dec_alu),
      .reg_we   (w_dec_we),
      .wnd_ld   (w_dec_wnd),
      .illegal  (w_dec_ill)
   );
`ifdef SEQ_TIMEOUT_EN
   logic [7:0] r_cnt;
   // The limit is hit on the MEM_TIMEOUT-th consecutive no-ack cycle; an ack in that cycle wins.
   assign w_tmo = w_mem_st && !mem_ack && r_cnt == 8'(MEM_TIMEOUT - 1);
   assign fault = !rst && r_state == S_FAULT;
   always_ff @(posedge clk) begin
      if (rst) r_cnt <= '0;
      else     r_cnt <= (w_mem_st && !mem_ack) ? r_cnt + 8'd1 : '0;
   end
`else
   assign w_tmo = MEM_TIMEOUT < 0;
   assign fault = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end
   // Everything is gated by rst so an in-flight access is dropped in the reset cycle itself.
   always_comb begin
      w_next   = r_state;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_ld    = 1'b0;
      pc_ld    = 1'b0;
      pc_src   = 1'b0;
      alu_func = A_NOP;
      reg_we   = 1'b0;
      reg_src  = 1'b0;
      wnd_ld   = 1'b0;
      window   = 2'd0;
      illegal  = 1'b0;
      halted   = 1'b0;
      if (!rst) begin
         case (r_state)
            S_FETCH: begin
               mem_req = 1'b1;
               ir_ld   = mem_ack;
               pc_ld   = mem_ack;
               w_next  = mem_ack ? S_DECODE : w_tmo ? S_FAULT : S_FETCH;
            end
            S_DECODE: begin
               pc_ld   = w_op == OP_JMP || (w_op == OP_BZ && zero);
               pc_src  = w_op == OP_JMP || w_op == OP_BZ;
               illegal = !(w_op inside {OP_ALU, OP_LOAD, OP_STORE, OP_JMP, OP_BZ, OP_HALT});
               w_next  = w_op == OP_ALU   ? S_EXEC   :
                         w_op == OP_LOAD  ? S_MEM_RD :
                         w_op == OP_STORE ? S_MEM_WR :
                         w_op == OP_HALT  ? S_HALT   : S_FETCH;
            end
            S_EXEC: begin
               alu_func = w_dec_alu;
               reg_we   = w_dec_we;
               wnd_ld   = w_dec_wnd;
               window   = w_dec_wnd ? w_func[1:0] : 2'd0;
               illegal  = w_dec_ill;
               w_next   = S_FETCH;
            end
            S_MEM_RD: begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
               reg_we   = mem_ack;
               reg_src  = mem_ack;
               w_next   = mem_ack ? S_FETCH : w_tmo ? S_FAULT : S_MEM_RD;
            end
            S_MEM_WR: begin
               mem_req  = 1'b1;
               mem_we   = 1'b1;
               addr_sel = 1'b1;
               w_next   = mem_ack ? S_FETCH : w_tmo ? S_FAULT : S_MEM_WR;
            end
            S_HALT:  halted = 1'b1;
            default: w_next = r_state;
         endcase
      end
   end
endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed scoreboard bench for mc_sequencer (SEQ_TIMEOUT_EN selects timeout checks).
module tb_mc_sequencer;
   typedef struct packed {
      logic       mem_req, mem_we, addr_sel, ir_ld, pc_ld, pc_src;
      logic [3:0] alu_func;
      logic       reg_we, reg_src, wnd_ld;
      logic [1:0] window;
      logic       illegal, halted, fault;
   } out_t;
   typedef struct {
      string tag;
      out_t  v;
   } sb_t;
   logic clk = 1'b0, rst, zero, mem_ack;
   logic [15:0] instr;
   out_t obs;
   sb_t sb[$];
   int n_vec = 0, n_miss = 0;
   always #5 clk = ~clk;
   mc_sequencer #(.MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ack(mem_ack),
      .mem_req(obs.mem_req), .mem_we(obs.mem_we), .addr_sel(obs.addr_sel),
      .ir_ld(obs.ir_ld), .pc_ld(obs.pc_ld), .pc_src(obs.pc_src),
      .alu_func(obs.alu_func), .reg_we(obs.reg_we), .reg_src(obs.reg_src),
      .wnd_ld(obs.wnd_ld), .window(obs.window), .illegal(obs.illegal),
      .halted(obs.halted), .fault(obs.fault)
   );
   function automatic out_t nop();
      out_t x = '0;
      x.alu_func = 4'd6;
      return x;
   endfunction
   function automatic out_t fe(input logic a);
      out_t x = nop();
      x.mem_req = 1'b1;
      x.ir_ld   = a;
      x.pc_ld   = a;
      return x;
   endfunction
   function automatic out_t dc(input logic ld, input logic src, input logic il);
      out_t x = nop();
      x.pc_ld   = ld;
      x.pc_src  = src;
      x.illegal = il;
      return x;
   endfunction
   function automatic out_t ex(input logic [3:0] f, input logic we, input logic wl,
                               input logic [1:0] w, input logic il);
      out_t x = nop();
      x.alu_func = f;
      x.reg_we   = we;
      x.wnd_ld   = wl;
      x.window   = w;
      x.illegal  = il;
      return x;
   endfunction
   function automatic out_t rd(input logic a);
      out_t x = nop();
      x.mem_req  = 1'b1;
      x.addr_sel = 1'b1;
      x.reg_we   = a;
      x.reg_src  = a;
      return x;
   endfunction
   function automatic out_t wr();
      out_t x = nop();
      x.mem_req  = 1'b1;
      x.mem_we   = 1'b1;
      x.addr_sel = 1'b1;
      return x;
   endfunction
   function automatic out_t hl();
      out_t x = nop();
      x.halted = 1'b1;
      return x;
   endfunction
   function automatic out_t ft();
      out_t x = nop();
      x.fault = 1'b1;
      return x;
   endfunction
   task automatic step(input string tag, input logic ack, input out_t e);
      sb_t s;
      mem_ack = ack;
      sb.push_back('{tag, e});
      @(negedge clk);
      s = sb.pop_front();
      n_vec++;
      assert (obs === s.v) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", s.tag, obs, s.v);
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1'b1; mem_ack = 1'b1; instr = 16'h0002; zero = 1'b0;
      step("rst_ack1", 1'b1, nop());
      step("rst_ack0", 1'b0, nop());
      rst = 1'b0;
      step("add_fetch", 1'b1, fe(1'b1));
      step("add_dec", 1'b1, dc(1'b0, 1'b0, 1'b0));
      step("add_exec", 1'b1, ex(4'd1, 1'b1, 1'b0, 2'd0, 1'b0));
      instr = 16'h0082;
      step("wnd_fetch", 1'b1, fe(1'b1));
      step("wnd_dec", 1'b1, nop());
      step("wnd_exec", 1'b1, ex(4'd6, 1'b0, 1'b1, 2'd2, 1'b0));
      for (int i = 0; i < 6; i++) begin
         instr = 16'(1 << i);
         step("alu_fetch", 1'b1, fe(1'b1));
         step("alu_dec", 1'b1, nop());
         step("alu_exec", 1'b1, ex(4'(i), 1'b1, 1'b0, 2'd0, 1'b0));
      end
      instr = 16'h0040;
      step("nop_fetch", 1'b1, fe(1'b1));
      step("nop_dec", 1'b1, nop());
      step("nop_exec", 1'b1, nop());
      instr = 16'h0083;
      step("wnd3_fetch", 1'b1, fe(1'b1));
      step("wnd3_dec", 1'b1, nop());
      step("wnd3_exec", 1'b1, ex(4'd6, 1'b0, 1'b1, 2'd3, 1'b0));
      instr = 16'h1000;
      step("ld_fetch", 1'b1, fe(1'b1));
      step("ld_dec", 1'b1, nop());
      for (int i = 0; i < 4; i++) step("ld_wait", 1'b0, rd(1'b0));
      step("ld_ack", 1'b1, rd(1'b1));
      instr = 16'h2000;
      step("st_fetch", 1'b1, fe(1'b1));
      step("st_dec", 1'b1, nop());
      step("st_wait", 1'b0, wr());
      step("st_ack", 1'b1, wr());
      instr = 16'h8000; zero = 1'b0;
      step("bz0_fetch", 1'b1, fe(1'b1));
      step("bz0_dec", 1'b1, dc(1'b0, 1'b1, 1'b0));
      zero = 1'b1;
      step("bz1_fetch", 1'b1, fe(1'b1));
      step("bz1_dec", 1'b1, dc(1'b1, 1'b1, 1'b0));
      zero = 1'b0; instr = 16'h4000;
      step("jmp_fetch", 1'b1, fe(1'b1));
      step("jmp_dec", 1'b1, dc(1'b1, 1'b1, 1'b0));
      instr = 16'h0003;
      step("illf_fetch", 1'b1, fe(1'b1));
      step("illf_dec", 1'b1, nop());
      step("illf_exec", 1'b1, ex(4'd6, 1'b0, 1'b0, 2'd0, 1'b1));
      instr = 16'h3000;
      step("illo_fetch", 1'b1, fe(1'b1));
      step("illo_dec", 1'b1, dc(1'b0, 1'b0, 1'b1));
      step("fwait0", 1'b0, fe(1'b0));
      step("fwait1", 1'b0, fe(1'b0));
      instr = 16'h1000;
      step("rr_fetch", 1'b1, fe(1'b1));
      step("rr_dec", 1'b1, nop());
      step("rr_wait", 1'b0, rd(1'b0));
      rst = 1'b1;
      step("rr_rst", 1'b0, nop());
      rst = 1'b0;
      step("rr_refetch", 1'b0, fe(1'b0));
`ifdef SEQ_TIMEOUT_EN
      step("tl_fetch", 1'b1, fe(1'b1));
      step("tl_dec", 1'b1, nop());
      for (int i = 0; i < 14; i++) step("tl_wait", 1'b0, rd(1'b0));
      step("tl_ack15", 1'b1, rd(1'b1));
      step("tl_back", 1'b1, fe(1'b1));
      rst = 1'b1;
      step("to_rst", 1'b0, nop());
      rst = 1'b0;
      for (int i = 0; i < 15; i++) step("to_wait", 1'b0, fe(1'b0));
      step("to_fault16", 1'b0, ft());
      step("to_absorb", 1'b1, ft());
      rst = 1'b1;
      step("to_clear", 1'b1, nop());
      rst = 1'b0;
`else
      for (int i = 0; i < 20; i++) step("nto_wait", 1'b0, fe(1'b0));
      step("nto_ack", 1'b1, fe(1'b1));
      step("nto_dec", 1'b1, nop());
      for (int i = 0; i < 20; i++) step("nto_rdwait", 1'b0, rd(1'b0));
      step("nto_rdack", 1'b1, rd(1'b1));
`endif
      instr = 16'hF000;
      step("hlt_fetch", 1'b1, fe(1'b1));
      step("hlt_dec", 1'b1, nop());
      for (int i = 0; i < 4; i++) step("hlt_stay", 1'b1, hl());
      rst = 1'b1;
      step("hlt_rst", 1'b1, nop());
      rst = 1'b0;
      step("hlt_restart", 1'b1, fe(1'b1));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle control sequencer for the processor datapath. It fetches each instruction over a shared memory handshake, decodes the opcode and ALU function field, and drives the datapath one step per state: ALU execute, load, store, jump, branch-on-zero, register-window load and halt. It sits between the instruction register and the ALU, register-file and window-pointer control inputs.

## Interface
- MEM_TIMEOUT, 15: consecutive no-ack cycles tolerated on one memory access before FAULT (1..255).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr  in  16  IR contents; opcode instr[15:12], func instr[7:0].
- zero  in  1  latched ALU zero flag.
- mem_ack  in  1  memory done; may assert in the same cycle as mem_req.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, valid with mem_req.
- addr_sel  out  1  0 = PC, 1 = IR address field.
- ir_ld  out  1  load IR from memory data.
- pc_ld  out  1  load PC.
- pc_src  out  1  0 = PC+1, 1 = IR target.
- alu_func  out  4  ALU op: MOVE 0, ADD 1, SUB 2, AND 3, OR 4, NOT 5, NOP 6.
- reg_we  out  1  register-file write.
- reg_src  out  1  0 = ALU result, 1 = memory data.
- wnd_ld  out  1  load window pointer.
- window  out  2  new window, equal to func[1:0].
- illegal  out  1  one-cycle pulse on an undefined opcode or func.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.

## Operation
- Opcodes: 0 ALU, 1 LOAD, 2 STORE, 4 JMP, 8 BZ, F HALT. All others are illegal and execute as NOP.
- ALU func codes (one-hot): MOVE 01, ADD 02, SUB 04, AND 08, OR 10, NOT 20, NOP 40, WND 80..83.
- States: FETCH, DECODE, EXEC, MEM_RD, MEM_WR, HALT, FAULT.
- FETCH: mem_req=1, addr_sel=0. On mem_ack, ir_ld=1 and pc_ld=1 with pc_src=0, then go to DECODE.
- DECODE:
  - ALU opcode goes to EXEC. LOAD goes to MEM_RD. STORE goes to MEM_WR. HALT goes to HALT.
  - JMP: pc_ld=1, pc_src=1, then FETCH.
  - BZ: pc_ld=zero, pc_src=1, then FETCH.
  - Illegal opcode: illegal=1, then FETCH.
- EXEC (one cycle, then FETCH):
  - MOVE..NOT: alu_func = code, reg_we=1, reg_src=0.
  - WND: wnd_ld=1, window=func[1:0].
  - NOP: no strobes.
  - Any other func: illegal=1, no strobes.
- MEM_RD: mem_req=1, addr_sel=1. On mem_ack, reg_we=1 and reg_src=1, then FETCH.
- MEM_WR: mem_req=1, mem_we=1, addr_sel=1. On mem_ack, go to FETCH.
- HALT and FAULT are absorbing; only rst leaves them.
- alu_func is 6 in every state except EXEC with a valid ALU func.
- ir_ld, pc_ld, reg_we and wnd_ld are strobes. Those tied to mem_ack are combinational on mem_ack; all others are Moore outputs.

## Timing
- Reset: while rst=1, all outputs are 0 except alu_func=6. The next state is FETCH. The first mem_req appears in the cycle after rst falls.
- Reset mid-access: the transaction is abandoned and mem_req drops in the same cycle rst is high.
- Zero-wait memory gives these minimum instruction lengths:
  - ALU: 3 cycles.
  - LOAD and STORE: 3 cycles.
  - JMP, BZ and illegal opcode: 2 cycles.
- Each wait cycle adds 1 to the instruction length.
- Timeout counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments on each cycle in those states with mem_ack=0.
  - When it reaches MEM_TIMEOUT, the next state is FAULT.
- If mem_ack is asserted in the same cycle the limit is reached, mem_ack wins.

## Configuration
- SEQ_TIMEOUT_EN defined: the timeout counter and the FAULT state are built.
- SEQ_TIMEOUT_EN undefined: the counter is removed and memory waits are unbounded. fault is tied to 0 and MEM_TIMEOUT is ignored.

## Structure
- Package seq_pkg holds:
  - opcode constants;
  - func one-hot constants;
  - ALU code constants;
  - the state enum.
- Sub-module seq_func_dec is a combinational func decoder. Inputs: func[7:0]. Outputs: alu_func, reg_we, wnd_ld, illegal.

## Test plan
- Reset release with mem_ack tied to 1, instr=0x0002 (ADD) → cycle 1 ir_ld=pc_ld=1; cycle 3 alu_func=1, reg_we=1.
- instr=0x0082 → EXEC wnd_ld=1, window=2, alu_func=6, reg_we=0.
- LOAD with mem_ack delayed 4 cycles → mem_req held for 5 cycles with addr_sel=1; reg_we=reg_src=1 in the ack cycle.
- BZ with zero=0 then zero=1 → pc_ld=0 then pc_ld=1 with pc_src=1; instruction length is 2 cycles.
- instr=0x0003 and opcode 3 → illegal pulses once per instruction and no strobes fire. instr=0xF000 → halted stays 1 and mem_req stays 0 until rst.
- SEQ_TIMEOUT_EN defined, MEM_TIMEOUT=15, mem_ack held at 0 → fault=1 from cycle 16. A variant with ack at wait 15 returns to FETCH. Asserting rst mid-wait restarts FETCH.
